tx_scheduler: RTL and testbench
===============================

TX_SCHEDULER -- requirements
Module: tx_scheduler

Interface
REQ-001 Parameter CRLF_EN, default 1: when 1, each result message ends with 0x0D then 0x0A.
REQ-002 Parameter TIMEOUT, default 4095: maximum cycles from a tx_start pulse to its tx_done; range 1..65535.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 echo_valid  in  1  echo requester has a byte.
REQ-006 echo_data  in  8  raw byte to retransmit unchanged.
REQ-007 echo_ready  out  1  echo byte is accepted when echo_valid & echo_ready.
REQ-008 res_valid  in  1  result requester has an ALU result.
REQ-009 res_data  in  8  unsigned ALU result, 0..255.
REQ-010 res_ready  out  1  result is accepted when res_valid & res_ready.
REQ-011 tx_start  out  1  one-cycle pulse that starts a UART transmitter character.
REQ-012 tx_data  out  8  character for the transmitter; valid in the tx_start cycle.
REQ-013 tx_busy  in  1  transmitter is occupied.
REQ-014 tx_done  in  1  one-cycle pulse when the transmitter finishes a character.
REQ-015 busy  out  1  a message is in progress.
REQ-016 owner  out  1  requester owning the current message: 0 = echo, 1 = result; holds its last value when idle.
REQ-017 err  out  1  one-cycle pulse on transmitter timeout.

Function
REQ-018 FSM states: IDLE, SEND, WAIT; busy SHALL be 1 in SEND and WAIT.
REQ-019 In IDLE, at most one of echo_ready/res_ready SHALL be 1, chosen by the round-robin rule; both SHALL be 0 outside IDLE.
REQ-020 Round-robin: if only one requester is valid, it is granted; if both are valid, the requester not granted last is granted; last_grant resets to echo, so the first tie goes to result.
REQ-021 On accept: capture the data, set owner, update last_grant, build the character queue, and go to SEND.
REQ-022 Echo message is one character, echo_data, with no CR/LF.
REQ-023 Result message is the decimal ASCII of res_data (0x30 + digit), most significant digit first.
REQ-024 Leading zeros SHALL be suppressed; value 0 SHALL send a single 0x30; a result message is 1-3 digits plus 0x0D, 0x0A when CRLF_EN=1.
REQ-025 SEND: if tx_busy=0, pulse tx_start with the current character, load the timeout counter, and go to WAIT; if tx_busy=1, hold with tx_start=0.
REQ-026 Latency: the first tx_start SHALL occur the cycle after accept when tx_busy=0.
REQ-027 WAIT: on tx_done, go to SEND if characters remain, otherwise go to IDLE; after the last tx_done, ready SHALL rise the next cycle.
REQ-028 A tx_done in any state other than WAIT SHALL be ignored.
REQ-029 Timeout: in WAIT, if tx_done has not arrived TIMEOUT cycles after tx_start, pulse err, drop the rest of the message, and go to IDLE.
REQ-030 tx_start SHALL never be 1 for two consecutive cycles and SHALL never be 1 while tx_busy=1.
REQ-031 New echo_valid/res_valid assertions during a message SHALL be neither accepted nor lost; the requester holds valid until it sees ready.

Reset
REQ-032 While rst=0, asynchronously: state=IDLE, tx_start=0, tx_data=0x00, busy=0, owner=0, err=0, echo_ready=0, res_ready=0, last_grant=echo, character queue and counter cleared.
REQ-033 Reset during a message SHALL discard the message; no further character of it SHALL be sent after release.
REQ-034 Ready outputs may assert from the first clock edge after rst returns to 1.

Verification
REQ-035 res_data=0x7B, CRLF_EN=1, tx_done 10 cycles after each start -> tx_data 0x31,0x32,0x33,0x0D,0x0A on 5 tx_start pulses; res_ready=0 until the cycle after the 5th tx_done.
REQ-036 res_data=0x00 -> 0x30,0x0D,0x0A; res_data=0x0A -> 0x31,0x30,0x0D,0x0A; res_data=0xFF -> 0x32,0x35,0x35,0x0D,0x0A.
REQ-037 After reset, echo_valid and res_valid both held high (echo_data=0x41, res_data=0x05) -> result message 0x35,0x0D,0x0A first, then echo 0x41; owner goes 1 then 0.
REQ-038 tx_busy=1 at accept for 7 cycles -> tx_start stays 0 for those cycles, then pulses in the first cycle with tx_busy=0.
REQ-039 TIMEOUT=20, tx_done never pulsed -> err pulses once 20 cycles after tx_start; state=IDLE; ready reasserts the next cycle; remaining characters are not sent.
REQ-040 rst=0 for 1 cycle after the 2nd character of result 0x7B -> tx_start and busy drop immediately; no 0x33/0x0D/0x0A follows; next accept starts a fresh message.

Source files
------------

// File: rtl/tx_scheduler.sv
// ----------------------------------------------------------------------------
// tx_scheduler
// Arbitrates between an echo requester and an ALU-result requester and feeds
// a byte-wide UART transmitter one character at a time.
//   - Echo message   : the raw echo byte, sent unchanged.
//   - Result message : decimal ASCII of the 8-bit result, leading zeros
//                      suppressed, optionally followed by CR LF.
// Requesters are served round-robin. Each character waits for the
// transmitter to be free, and each tx_start must be answered by tx_done
// within TIMEOUT cycles or the rest of the message is dropped and err pulses.
//
// Ports
//   clk, rst               clock; asynchronous active-low reset
//   echo_valid/data/ready  echo requester handshake (8-bit raw byte)
//   res_valid/data/ready   result requester handshake (8-bit unsigned value)
//   tx_start, tx_data      one-cycle character strobe and byte to transmitter
//   tx_busy, tx_done       transmitter occupied / character finished
//   busy                   a message is in progress
//   owner                  0 = echo, 1 = result; holds last value when idle
//   err                    one-cycle pulse on transmitter timeout
// ----------------------------------------------------------------------------
module tx_scheduler #(
   parameter bit          CRLF_EN = 1'b1,
   parameter int unsigned TIMEOUT = 4095
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       echo_valid,
   input  logic [7:0] echo_data,
   output logic       echo_ready,
   input  logic       res_valid,
   input  logic [7:0] res_data,
   output logic       res_ready,
   output logic       tx_start,
   output logic [7:0] tx_data,
   input  logic       tx_busy,
   input  logic       tx_done,
   output logic       busy,
   output logic       owner,
   output logic       err
);

   localparam logic [15:0] TIMEOUT_LOAD = 16'(TIMEOUT);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      WAIT = 2'd2
   } state_t;

   state_t      state_reg;
   logic [7:0]  q_reg [8];      // character queue of the current message
   logic [2:0]  len_reg;        // number of characters in the queue
   logic [2:0]  idx_reg;        // character currently being sent
   logic [2:0]  idx_next;
   logic [15:0] cnt_reg;        // cycles left before a missing tx_done is a timeout
   logic        owner_reg;
   logic        last_grant_reg; // 0 = echo, 1 = result
   logic        run_reg;        // low until the first clock edge after reset release

   logic        offer;
   logic        grant_res;
   logic        grant_echo;
   logic        accept;
   logic        timeout_hit;
   logic [7:0]  hund;
   logic [7:0]  tens;
   logic [7:0]  ones;
   logic [7:0]  build_q [8];
   logic [2:0]  build_len;

   // Round-robin: a lone requester always wins; on a tie the one that was
   // not served last wins.
   assign grant_res  = res_valid & (~echo_valid | ~last_grant_reg);
   assign grant_echo = echo_valid & ~grant_res;

   assign offer      = run_reg & (state_reg == IDLE);
   assign echo_ready = offer & grant_echo;
   assign res_ready  = offer & grant_res;
   assign accept     = offer & (echo_valid | res_valid);

   // tx_start is qualified by the live tx_busy so it can never coincide with
   // a busy transmitter, and it only lasts the one SEND cycle it is taken in.
   assign tx_start   = (state_reg == SEND) & ~tx_busy;
   assign tx_data    = q_reg[idx_reg];
   assign busy       = (state_reg != IDLE);
   assign owner      = owner_reg;

   // A tx_done arriving in the very last allowed cycle still counts.
   assign timeout_hit = (state_reg == WAIT) & ~tx_done & (cnt_reg == 16'd1);
   assign err         = timeout_hit;

   assign idx_next = idx_reg + 3'd1;

   // Message builder: evaluated every cycle, loaded only on accept.
   always_comb begin
      hund = res_data / 8'd100;
      tens = (res_data / 8'd10) % 8'd10;
      ones = res_data % 8'd10;
      for (int i = 0; i < 8; i++) begin
         build_q[i] = 8'h00;
      end
      build_len = 3'd0;
      if (grant_res) begin
         if (hund != 8'd0) begin
            build_q[0] = 8'h30 + hund;
            build_q[1] = 8'h30 + tens;
            build_q[2] = 8'h30 + ones;
            build_len  = 3'd3;
         end else if (tens != 8'd0) begin
            build_q[0] = 8'h30 + tens;
            build_q[1] = 8'h30 + ones;
            build_len  = 3'd2;
         end else begin
            build_q[0] = 8'h30 + ones;
            build_len  = 3'd1;
         end
         if (CRLF_EN) begin
            build_q[build_len]        = 8'h0D;
            build_q[build_len + 3'd1] = 8'h0A;
            build_len                 = build_len + 3'd2;
         end
      end else begin
         build_q[0] = echo_data;
         build_len  = 3'd1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 8; i++) begin
            q_reg[i] <= 8'h00;
         end
      end else if (accept) begin
         for (int i = 0; i < 8; i++) begin
            q_reg[i] <= build_q[i];
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg      <= IDLE;
         len_reg        <= 3'd0;
         idx_reg        <= 3'd0;
         cnt_reg        <= 16'd0;
         owner_reg      <= 1'b0;
         last_grant_reg <= 1'b0;
         run_reg        <= 1'b0;
      end else begin
         run_reg <= 1'b1;
         case (state_reg)
            IDLE: begin
               if (accept) begin
                  owner_reg      <= grant_res;
                  last_grant_reg <= grant_res;
                  len_reg        <= build_len;
                  idx_reg        <= 3'd0;
                  state_reg      <= SEND;
               end
            end
            SEND: begin
               if (!tx_busy) begin
                  cnt_reg   <= TIMEOUT_LOAD;
                  state_reg <= WAIT;
               end
            end
            WAIT: begin
               if (tx_done) begin
                  if (idx_next < len_reg) begin
                     idx_reg   <= idx_next;
                     state_reg <= SEND;
                  end else begin
                     state_reg <= IDLE;
                  end
               end else if (timeout_hit) begin
                  state_reg <= IDLE;
               end else begin
                  cnt_reg <= cnt_reg - 16'd1;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_tx_scheduler.sv
// ----------------------------------------------------------------------------
// tb_tx_scheduler
// Table-driven bench for tx_scheduler (CRLF_EN=1, TIMEOUT=20). A simple
// transmitter model answers every tx_start with tx_done ten cycles later.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
// ----------------------------------------------------------------------------
module tb_tx_scheduler;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       echo_valid = 1'b0;
   logic [7:0] echo_data = 8'h00;
   logic       echo_ready;
   logic       res_valid = 1'b0;
   logic [7:0] res_data = 8'h00;
   logic       res_ready;
   logic       tx_start;
   logic [7:0] tx_data;
   logic       tx_busy = 1'b0;
   logic       tx_done = 1'b0;
   logic       busy;
   logic       owner;
   logic       err;

   always #5 clk = ~clk;

   tx_scheduler #(.CRLF_EN(1'b1), .TIMEOUT(20)) dut (
      .clk        (clk),
      .rst        (rst),
      .echo_valid (echo_valid),
      .echo_data  (echo_data),
      .echo_ready (echo_ready),
      .res_valid  (res_valid),
      .res_data   (res_data),
      .res_ready  (res_ready),
      .tx_start   (tx_start),
      .tx_data    (tx_data),
      .tx_busy    (tx_busy),
      .tx_done    (tx_done),
      .busy       (busy),
      .owner      (owner),
      .err        (err)
   );

   typedef struct {
      bit          is_res;
      logic [7:0]  data;
      int          n;
      logic [39:0] chars;   // expected characters, first one in the top byte
   } vec_t;

   vec_t vecs [9];

   int   n_checks = 0;
   int   n_fail = 0;
   int   cyc = 0;
   bit   echo_hs = 1'b0;
   bit   res_hs = 1'b0;
   bit   prev_start = 1'b0;
   bit   auto_done = 1'b1;
   int   done_cd = 0;
   int   busy_hold = 0;
   int   first_start_cyc = 0;
   int   last_done_cyc = 0;
   int   acc_cyc = 0;
   int   err_cnt = 0;
   int   err_cyc = 0;
   int   prot = 0;
   logic [7:0] got_q [$];
   bit         own_q [$];

   task automatic check(input string name, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
      end
   endtask

   // One clock cycle: update requester/transmitter models, then sample.
   task automatic cycle();
      @(negedge clk);
      cyc++;
      if (echo_hs) echo_valid = 1'b0;
      if (res_hs)  res_valid  = 1'b0;
      tx_done = 1'b0;
      if (done_cd > 0) begin
         done_cd--;
         if (done_cd == 0) tx_done = 1'b1;
      end
      if (busy_hold > 0) begin
         tx_busy = 1'b1;
         busy_hold--;
      end else begin
         tx_busy = 1'b0;
      end
      #1;
      echo_hs = echo_valid && echo_ready;
      res_hs  = res_valid && res_ready;
      if (echo_ready && res_ready) prot++;
      if ((echo_ready || res_ready) && busy) prot++;
      if (tx_start && tx_busy) prot++;
      if (tx_start && prev_start) prot++;
      prev_start = tx_start;
      if (tx_start) begin
         if (got_q.size() == 0) first_start_cyc = cyc;
         got_q.push_back(tx_data);
         own_q.push_back(owner);
         if (auto_done) done_cd = 10;
      end
      if (tx_done) last_done_cyc = cyc;
      if (err) begin
         err_cnt++;
         err_cyc = cyc;
      end
   endtask

   // Re-sample handshakes after the bench changed a valid mid-cycle.
   task automatic settle();
      #1;
      echo_hs = echo_valid && echo_ready;
      res_hs  = res_valid && res_ready;
   endtask

   task automatic wait_accept(input string name, input bit is_res);
      int k;
      k = 0;
      settle();
      while (!(is_res ? res_hs : echo_hs) && k < 40) begin
         cycle();
         k++;
      end
      check($sformatf("%s accept", name), int'(is_res ? res_hs : echo_hs), 1);
      acc_cyc = cyc;
   endtask

   task automatic run_to_idle(input string name);
      int k;
      k = 0;
      do begin
         cycle();
         k++;
      end while (busy && k < 400);
      check($sformatf("%s idle", name), int'(busy), 0);
   endtask

   task automatic check_chars(input string name, input int n, input logic [39:0] chars);
      logic [7:0] e;
      check($sformatf("%s count", name), got_q.size(), n);
      for (int i = 0; i < n; i++) begin
         e = chars[39 - 8*i -: 8];
         check($sformatf("%s char%0d", name, i),
               (i < got_q.size()) ? int'(got_q[i]) : -1, int'(e));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got running, required finished");
      $fatal(1);
   end

   initial begin
      string nm;
      int    bad;
      int    k;
      bit    exp_own [4];

      vecs[0] = '{1'b1, 8'h7B, 5, 40'h313233_0D0A};
      vecs[1] = '{1'b1, 8'h00, 3, 40'h300D0A_0000};
      vecs[2] = '{1'b1, 8'h0A, 4, 40'h31300D_0A00};
      vecs[3] = '{1'b1, 8'hFF, 5, 40'h323535_0D0A};
      vecs[4] = '{1'b1, 8'h64, 5, 40'h313030_0D0A};
      vecs[5] = '{1'b1, 8'h09, 3, 40'h390D0A_0000};
      vecs[6] = '{1'b0, 8'h41, 1, 40'h410000_0000};
      vecs[7] = '{1'b0, 8'h0D, 1, 40'h0D0000_0000};
      vecs[8] = '{1'b1, 8'h2A, 4, 40'h34320D_0A00};

      // ---------------- reset state, both requesters waiting -------------
      echo_data  = 8'h41;
      res_data   = 8'h05;
      echo_valid = 1'b1;
      res_valid  = 1'b1;
      #2 rst = 1'b0;
      repeat (3) cycle();
      check("rst echo_ready", int'(echo_ready), 0);
      check("rst res_ready", int'(res_ready), 0);
      check("rst tx_start", int'(tx_start), 0);
      check("rst tx_data", int'(tx_data), 0);
      check("rst busy", int'(busy), 0);
      check("rst owner", int'(owner), 0);
      check("rst err", int'(err), 0);

      // ---------------- first tie after reset goes to result -------------
      rst = 1'b1;
      got_q.delete(); own_q.delete(); prot = 0;
      k = 0;
      while ((echo_valid || res_valid || busy) && k < 200) begin
         cycle();
         k++;
      end
      exp_own = '{1'b1, 1'b1, 1'b1, 1'b0};
      check_chars("rr", 4, 40'h350D0A_4100);
      bad = 0;
      foreach (own_q[i]) if (i < 4 && own_q[i] != exp_own[i]) bad++;
      check("rr owner order", bad, 0);
      check("rr owner idle", int'(owner), 0);
      check("rr protocol", prot, 0);
      $display("msg rr: %0d chars, result then echo", got_q.size());

      // ---------------- table of single messages -------------------------
      for (int v = 0; v < 9; v++) begin
         nm = $sformatf("vec%0d", v);
         got_q.delete(); own_q.delete(); prot = 0;
         if (vecs[v].is_res) begin
            res_data  = vecs[v].data;
            res_valid = 1'b1;
         end else begin
            echo_data  = vecs[v].data;
            echo_valid = 1'b1;
         end
         wait_accept(nm, vecs[v].is_res);
         run_to_idle(nm);
         check_chars(nm, vecs[v].n, vecs[v].chars);
         bad = 0;
         foreach (own_q[i]) if (own_q[i] != vecs[v].is_res) bad++;
         check($sformatf("%s owner", nm), bad, 0);
         check($sformatf("%s owner idle", nm), int'(owner), int'(vecs[v].is_res));
         check($sformatf("%s first start latency", nm), first_start_cyc - acc_cyc, 1);
         check($sformatf("%s idle after last done", nm), cyc - last_done_cyc, 1);
         check($sformatf("%s protocol", nm), prot, 0);
         $display("msg %s: data 0x%02h, %0d chars, accepted at cycle %0d",
                  nm, vecs[v].data, got_q.size(), acc_cyc);
      end
      check("no err in normal traffic", err_cnt, 0);

      // ---------------- transmitter busy at accept -----------------------
      got_q.delete(); own_q.delete(); prot = 0;
      res_data  = 8'h05;
      res_valid = 1'b1;
      tx_busy   = 1'b1;
      busy_hold = 6;
      wait_accept("txbusy", 1'b1);
      run_to_idle("txbusy");
      check("txbusy first start", first_start_cyc - acc_cyc, 7);
      check_chars("txbusy", 3, 40'h350D0A_0000);
      check("txbusy protocol", prot, 0);
      $display("msg txbusy: first tx_start %0d cycles after accept", first_start_cyc - acc_cyc);

      // ---------------- timeout, echo arrives during the message ---------
      got_q.delete(); own_q.delete(); prot = 0;
      auto_done = 1'b0;
      res_data  = 8'h7B;
      res_valid = 1'b1;
      wait_accept("tmo", 1'b1);
      cycle();
      echo_data  = 8'h55;
      echo_valid = 1'b1;
      settle();
      k = 0;
      while (err_cnt == 0 && k < 60) begin
         cycle();
         k++;
      end
      check("tmo err seen", err_cnt, 1);
      check("tmo err cycle", err_cyc - first_start_cyc, 20);
      auto_done = 1'b1;
      cycle();
      check("tmo busy after err", int'(busy), 0);
      check("tmo ready next cycle", int'(echo_hs), 1);
      run_to_idle("tmo echo");
      check_chars("tmo", 2, 40'h315500_0000);
      check("tmo err count", err_cnt, 1);
      check("tmo protocol", prot, 0);
      $display("msg tmo: err %0d cycles after tx_start, %0d chars total", err_cyc - first_start_cyc, got_q.size());

      // ---------------- reset in the middle of a result message ----------
      got_q.delete(); own_q.delete(); prot = 0;
      res_data  = 8'h7B;
      res_valid = 1'b1;
      wait_accept("mrst", 1'b1);
      k = 0;
      while (got_q.size() < 2 && k < 60) begin
         cycle();
         k++;
      end
      check("mrst two chars", got_q.size(), 2);
      cycle();
      cycle();
      rst = 1'b0;
      #1;
      check("mrst busy drops", int'(busy), 0);
      check("mrst tx_start low", int'(tx_start), 0);
      check("mrst tx_data", int'(tx_data), 0);
      check("mrst owner", int'(owner), 0);
      @(negedge clk);
      rst = 1'b1;
      repeat (30) cycle();
      check("mrst no resume", got_q.size(), 2);
      check("mrst protocol", prot, 0);
      got_q.delete(); own_q.delete();
      res_data  = 8'h05;
      res_valid = 1'b1;
      wait_accept("fresh", 1'b1);
      run_to_idle("fresh");
      check_chars("fresh", 3, 40'h350D0A_0000);
      check("fresh first start latency", first_start_cyc - acc_cyc, 1);
      $display("msg fresh: %0d chars after mid-message reset", got_q.size());

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
